// File: rtl/line_window_buffer.sv
// 3x3 sliding window over a raster pixel stream, built from two circular line memories.
// Window, centre coordinates and valid appear one cycle after each accepted pixel; idle cycles freeze everything.
module line_window_buffer #(
  parameter int W  = 640,
  parameter int H  = 480,
  parameter int DW = 8,
  parameter int CB = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   pix_in,
  input  logic            pix_val,
  output logic [9*DW-1:0] win_out,
  output logic            win_val,
  output logic [CB-1:0]   col_c,
  output logic [CB-1:0]   row_c,
  output logic            frame_done
);

  localparam int            AW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CB-1:0] COL_LAST = CB'(W - 1);
  localparam logic [CB-1:0] ROW_LAST = CB'(H - 1);
  localparam logic [CB-1:0] ONE      = CB'(1);
  localparam logic [CB-1:0] TWO      = CB'(2);

  logic [DW-1:0] line1_q [W];
  logic [DW-1:0] line2_q [W];
  logic [DW-1:0] line1_rd, line2_rd;
  logic [AW-1:0] addr;

  logic [CB-1:0] col_q, col_d, row_q, row_d;
  logic [CB-1:0] col_c_q, col_c_d, row_c_q, row_c_d;
  logic [DW-1:0] tap_q [9];
  logic [DW-1:0] tap_d [9];
  logic          win_val_q, win_val_d;
  logic          frame_done_q, frame_done_d;
  logic          last_col, last_row;

  assign addr     = col_q[AW-1:0];
  assign line1_rd = line1_q[addr];
  assign line2_rd = line2_q[addr];
  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    col_c_d      = col_c_q;
    row_c_d      = row_c_q;
    tap_d        = tap_q;
    win_val_d    = 1'b0;
    frame_done_d = 1'b0;
    if (pix_val) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
      for (int r = 0; r < 3; r++) begin
        tap_d[3*r]   = tap_q[3*r+1];
        tap_d[3*r+1] = tap_q[3*r+2];
      end
      // Newest column: two lines back, one line back, current pixel.
      tap_d[2]     = line2_rd;
      tap_d[5]     = line1_rd;
      tap_d[8]     = pix_in;
      win_val_d    = (row_q >= TWO) && (col_q >= TWO);
      col_c_d      = col_q - ONE;
      row_c_d      = row_q - ONE;
      frame_done_d = last_col && last_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      col_c_q      <= '0;
      row_c_q      <= '0;
      win_val_q    <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 9; k++) tap_q[k] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      col_c_q      <= col_c_d;
      row_c_q      <= row_c_d;
      win_val_q    <= win_val_d;
      frame_done_q <= frame_done_d;
      tap_q        <= tap_d;
    end
  end

  // Line memories are never cleared; row/column gating hides stale contents.
  always_ff @(posedge clk) begin
    if (pix_val && !rst) begin
      line1_q[addr] <= pix_in;
      line2_q[addr] <= line1_rd;
    end
  end

  always_comb begin
    win_out = '0;
    for (int k = 0; k < 9; k++) win_out[k*DW +: DW] = tap_q[k];
  end

  assign win_val    = win_val_q;
  assign col_c      = col_c_q;
  assign row_c      = row_c_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter W, default 640, meaning pixels per image line.
REQ-002 SHALL have parameter H, default 480, meaning lines per frame.
REQ-003 SHALL have parameter DW, default 8, meaning pixel width in bits.
REQ-004 SHALL have parameter CB, default 10, meaning column/row counter width; CB >= clog2(max(W,H)).
REQ-005 SHALL have port clk, input, 1, meaning clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, synchronous, active-high.
REQ-007 SHALL have port pix_in, input, DW, meaning raster-order pixel.
REQ-008 SHALL have port pix_val, input, 1, meaning pix_in valid this cycle.
REQ-009 SHALL have port win_out, output, 9*DW, meaning 3x3 window; tap k = 3*r+c occupies bits [DW*(k+1)-1 : DW*k], with r=0 the oldest row and c=0 the oldest column.
REQ-010 SHALL have port win_val, output, 1, meaning win_out holds a complete in-frame window.
REQ-011 SHALL have port col_c, output, CB, meaning column of window centre.
REQ-012 SHALL have port row_c, output, CB, meaning row of window centre.
REQ-013 SHALL have port frame_done, output, 1, meaning one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-014 SHALL hold input counters col_i (0..W-1) and row_i (0..H-1) addressing the next accepted pixel.
REQ-015 SHALL, per accepted pixel (pix_val=1): col_i at W-1 -> 0 and row_i increments; otherwise col_i increments.
REQ-016 SHALL wrap row_i from H-1 to 0 when col_i wraps on row H-1.
REQ-017 SHALL keep two circular line memories of depth W, addressed by col_i, with no separate read pointer.
REQ-018 SHALL, on an accepted pixel, write pix_in to line1[col_i] and the old line1[col_i] to line2[col_i] in the same cycle, using read-before-write.
REQ-019 SHALL, on an accepted pixel, shift window columns left (c=0 <- c=1 <- c=2) and load column c=2 with {line2[col_i], line1[col_i], pix_in} for rows r=0,1,2.
REQ-020 SHALL freeze counters, memories, window, col_c and row_c when pix_val=0, and drive win_val=0 that cycle.
REQ-021 SHALL register win_val one cycle after acceptance: win_val=1 iff row_i>=2 and col_i>=2 for the accepted pixel; latency exactly 1 cycle.
REQ-022 SHALL register col_c=col_i-1 and row_c=row_i-1 of the accepted pixel, in the same cycle as win_val.
REQ-023 SHALL treat windows straddling a line wrap (col_i=0 or 1) or the top two rows as invalid; win_out content is don't-care then.
REQ-024 SHALL pulse frame_done for one cycle, one cycle after accepting the pixel at (W-1, H-1), coincident with that pixel's win_val.
REQ-025 SHALL process back-to-back pix_val=1 at full rate, one pixel per clock, with no stalls.
REQ-026 SHALL retain line memory contents across a frame wrap; row gating (REQ-021) excludes stale rows.

Reset
REQ-027 SHALL, while rst=1, set col_i=0, row_i=0, window taps=0, win_val=0, col_c=0, row_c=0, frame_done=0, ignoring pix_val.
REQ-028 SHALL NOT clear line memories on reset; invalid data SHALL be suppressed by counter gating only.
REQ-029 SHALL, when rst asserts mid-frame, restart at (0,0) on the first accepted pixel after rst deasserts; no win_val before row_i=2,col_i=2 of the new frame.

Verification
REQ-030 SHALL cover, with W=8, H=6, pix_in=row*8+col: continuous stream -> first win_val one cycle after pixel (2,2), win_out taps k=0..8 = 0,1,2,8,9,10,16,17,18, col_c=1, row_c=1.
REQ-031 SHALL cover continuous stream over a full frame -> exactly (W-2)*(H-2)=24 win_val pulses, and frame_done one cycle after pixel (7,5) with col_c=6, row_c=4.
REQ-032 SHALL cover random pix_val gaps (~50% duty) -> identical sequence of (win_out, col_c, row_c) to the gapless run, with win_val=0 on every idle cycle.
REQ-033 SHALL cover the line wrap -> no win_val for accepted pixels at col 0 and 1 of rows 2..5.
REQ-034 SHALL cover rst pulsed after 20 pixels, then a new frame of value 0xFF everywhere -> first win_val after new pixel (2,2) with all taps 0xFF, no stale values.
REQ-035 SHALL cover two back-to-back frames -> second frame windows equal the reference model output, and frame_done pulses exactly twice.
